// File: rtl/seq_detect_param_if.sv
// Bit-stream, configuration and status bundle of the serial pattern detector.
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [PAT_W-1:0] cfg_mask;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             flag;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output din_valid, din, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
        input  flag, match_cnt, cnt_sat
    );

    modport slave (
        input  din_valid, din, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
        output flag, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with programmable pattern, don't-care mask and overlap
// mode; registered match pulse plus a saturating match counter.
module seq_detect_param #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    seq_detect_param_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [FILL_W-1:0] fill, fill_nxt, fill_inc;
    logic [PAT_W-1:0] hist, hist_nxt;
    logic [PAT_W-1:0] pat_r, mask_r;
    logic             ovl_r;
    logic             accept, full_nxt, hit;
    logic             flag_q, flag_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             sat_q;

    // Bit acceptance and match evaluation against the post-shift history
    always_comb begin
        accept   = bus.din_valid & ~bus.cfg_load;
        hist_nxt = {hist[PAT_W-2:0], bus.din};
        fill_inc = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        full_nxt = (fill_inc == FILL_W'(PAT_W));
        hit      = accept & full_nxt & (((hist_nxt ^ pat_r) & ~mask_r) == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            fill  <= '0;
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
        end
    end

    // Next state: non-overlap matches restart the fill so history is not reused
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        if (bus.cfg_load) begin
            state_nxt = FILL;
            fill_nxt  = '0;
        end else if (accept) begin
            fill_nxt = fill_inc;
            unique case (state)
                FILL:    if (full_nxt) state_nxt = ARMED;
                ARMED:   state_nxt = ARMED;
                default: state_nxt = FILL;
            endcase
            if (hit && !ovl_r) begin
                state_nxt = FILL;
                fill_nxt  = '0;
            end
        end
    end

    // Output logic: clear wins over increment, but the pulse still fires
    always_comb begin
        flag_nxt = hit;
        cnt_nxt  = cnt_q;
        if (bus.cnt_clr) begin
            cnt_nxt = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '0;
            pat_r  <= '0;
            mask_r <= '0;
            ovl_r  <= 1'b1;
            flag_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                pat_r  <= bus.cfg_pattern;
                mask_r <= bus.cfg_mask;
                ovl_r  <= bus.cfg_overlap;
            end
            if (accept) hist <= hist_nxt;
            flag_q <= flag_nxt;
            cnt_q  <= cnt_nxt;
            sat_q  <= (cnt_nxt == CNT_MAX);
        end
    end

    assign bus.flag      = flag_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule
